// File: rtl/edge_cov_acc.sv
// Sticky edge-coverage accumulator: ORs NUM_CH edge-mask channels into a
// coverage vector, serves registered word reads and counts covered bits with
// a word-serial popcount scan.
// Optional feature macro: COV_NEW_DET_EN (adds new_hit / new_hit_cnt).
module edge_cov_acc #(
  parameter  int unsigned NUM_CH = 8,
  parameter  int unsigned CH_W   = 512,
  parameter  int unsigned RD_W   = 32,
  localparam int unsigned TOT    = NUM_CH * CH_W,
  localparam int unsigned WORDS  = TOT / RD_W,
  localparam int unsigned AW     = $clog2(WORDS),
  localparam int unsigned CW     = $clog2(TOT + 1)
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [TOT-1:0]  mask_in,
  input  logic            mask_vld,
  input  logic            clr,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_ack,
  input  logic            scan_start,
  output logic            scan_busy,
  output logic            scan_done,
  output logic [CW-1:0]   cov_count
`ifdef COV_NEW_DET_EN
  ,
  output logic            new_hit,
  output logic [15:0]     new_hit_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [TOT-1:0]  r_cov;
  logic [RD_W-1:0] w_words [WORDS];
  logic            w_rd_in_range;
  logic [RD_W-1:0] r_rd_data;
  logic            r_rd_ack;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_acc, w_acc_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;

  // Number of set bits in one readout word.
  function automatic logic [CW-1:0] f_popcnt(input logic [RD_W-1:0] w);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(RD_W); i++) begin
      n = n + CW'(w[i]);
    end
    return n;
  endfunction

  // Word-indexed view of the coverage vector.
  for (genvar k = 0; k < int'(WORDS); k++) begin : g_words
    assign w_words[k] = r_cov[k*RD_W +: RD_W];
  end

  assign w_rd_in_range = (32'(rd_addr) < WORDS);

  // Sticky coverage: clr wins over a same-cycle mask.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cov <= '0;
    end else if (clr) begin
      r_cov <= '0;
    end else if (mask_vld) begin
      r_cov <= r_cov | mask_in;
    end
  end

  // Registered readout of the pre-update coverage word, one ack per request.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_rd_data <= '0;
      r_rd_ack  <= 1'b0;
    end else begin
      r_rd_ack <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_in_range ? w_words[rd_addr] : '0;
      end
    end
  end

  // Scan FSM state and datapath registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Scan next-state: one word per cycle, publish total on the DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_count_nxt = r_count;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_acc_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_start) begin
            w_state_nxt = S_SCAN;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
            w_busy_nxt  = 1'b1;
          end
        end
        S_SCAN: begin
          w_acc_nxt = r_acc + f_popcnt(w_words[r_idx]);
          w_idx_nxt = r_idx + AW'(1);
          if (r_idx == AW'(WORDS - 1)) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          w_count_nxt = r_acc;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_ack    = r_rd_ack;
  assign scan_busy = r_busy;
  assign scan_done = r_done;
  assign cov_count = r_count;

`ifdef COV_NEW_DET_EN
  logic        w_new_bits;
  logic        r_new_hit;
  logic [15:0] r_new_hit_cnt;

  assign w_new_bits = |(mask_in & ~r_cov);

  // Flag and count mask cycles that uncover at least one fresh bit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_new_hit     <= 1'b0;
      r_new_hit_cnt <= '0;
    end else if (clr) begin
      r_new_hit     <= 1'b0;
      r_new_hit_cnt <= '0;
    end else begin
      r_new_hit <= mask_vld && w_new_bits;
      if (mask_vld && w_new_bits && (r_new_hit_cnt != 16'hFFFF)) begin
        r_new_hit_cnt <= r_new_hit_cnt + 16'd1;
      end
    end
  end

  assign new_hit     = r_new_hit;
  assign new_hit_cnt = r_new_hit_cnt;
`endif

endmodule

// File: tb/tb_edge_cov_acc.sv
// Self-checking bench for edge_cov_acc at default parameters.
// Optional feature macro: COV_NEW_DET_EN (also checks new_hit / new_hit_cnt).
module tb_edge_cov_acc;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 512;
  localparam int unsigned RD_W   = 32;
  localparam int unsigned TOT    = NUM_CH * CH_W;
  localparam int unsigned WORDS  = TOT / RD_W;
  localparam int unsigned AW     = 7;
  localparam int unsigned CW     = 13;

  logic            CLK;
  logic            RST_n;
  logic [TOT-1:0]  mask_in;
  logic            mask_vld;
  logic            clr;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic [RD_W-1:0] rd_data;
  logic            rd_ack;
  logic            scan_start;
  logic            scan_busy;
  logic            scan_done;
  logic [CW-1:0]   cov_count;
`ifdef COV_NEW_DET_EN
  logic            new_hit;
  logic [15:0]     new_hit_cnt;
`endif

  edge_cov_acc dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .mask_in    (mask_in),
    .mask_vld   (mask_vld),
    .clr        (clr),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .cov_count  (cov_count)
`ifdef COV_NEW_DET_EN
    ,
    .new_hit    (new_hit),
    .new_hit_cnt(new_hit_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec;
  int n_err;

  // Reference coverage held as plain words.
  logic [RD_W-1:0] m_words [WORDS];
`ifdef COV_NEW_DET_EN
  int m_nh_cnt;
`endif

  typedef struct {
    int unsigned     word;
    logic [RD_W-1:0] val;
    int unsigned     rd;
    logic [RD_W-1:0] exp_rd;
  } vec_t;

  vec_t tbl [6];
`ifdef COV_NEW_DET_EN
  logic exp_nh_tbl [6];
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_pop();
    int s;
    s = 0;
    for (int w = 0; w < int'(WORDS); w++) s += $countones(m_words[w]);
    return s;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < int'(WORDS); w++) m_words[w] = '0;
`ifdef COV_NEW_DET_EN
    m_nh_cnt = 0;
`endif
  endtask

  // One clock: drive inputs, advance the model, check read/new-hit results.
  task automatic tick(input logic vld, input logic [TOT-1:0] m, input logic c,
                      input logic req, input logic [AW-1:0] a, input logic st);
    logic [RD_W-1:0] exp_rd;
    logic            nh;
    mask_in    = m;
    mask_vld   = vld;
    clr        = c;
    rd_req     = req;
    rd_addr    = a;
    scan_start = st;
    exp_rd = m_words[a];
    nh = 1'b0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (vld && !c && ((m[w*RD_W +: RD_W] & ~m_words[w]) != '0)) nh = 1'b1;
    end
    if (c) begin
      model_clear();
    end else if (vld) begin
      for (int w = 0; w < int'(WORDS); w++) m_words[w] = m_words[w] | m[w*RD_W +: RD_W];
    end
`ifdef COV_NEW_DET_EN
    if (nh && m_nh_cnt < 65535) m_nh_cnt++;
`endif
    @(posedge CLK);
    #1;
    chk("rd_ack", 64'(rd_ack), 64'(req));
    if (req) chk("rd_data", 64'(rd_data), 64'(exp_rd));
`ifdef COV_NEW_DET_EN
    chk("new_hit", 64'(new_hit), 64'(nh));
    chk("new_hit_cnt", 64'(new_hit_cnt), 64'(m_nh_cnt));
`else
    if (nh) begin end
`endif
    mask_in    = '0;
    mask_vld   = 1'b0;
    clr        = 1'b0;
    rd_req     = 1'b0;
    scan_start = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic run_scan(input int exp_cnt);
    int cycles;
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("scan_busy_start", 64'(scan_busy), 64'(1));
    cycles = 0;
    while (scan_done !== 1'b1 && cycles < 300) begin
      idle();
      cycles++;
    end
    chk("scan_done_seen", 64'(scan_done), 64'(1));
    chk("scan_latency", 64'(cycles), 64'(WORDS + 1));
    chk("cov_count", 64'(cov_count), 64'(exp_cnt));
    chk("scan_busy_end", 64'(scan_busy), 64'(0));
    idle();
    chk("scan_done_pulse", 64'(scan_done), 64'(0));
  endtask

  task automatic apply_vec(input int i);
    logic [TOT-1:0] m;
    m = '0;
    m[tbl[i].word*RD_W +: RD_W] = tbl[i].val;
    tick(1'b1, m, 1'b0, 1'b0, '0, 1'b0);
`ifdef COV_NEW_DET_EN
    chk("tbl_new_hit", 64'(new_hit), 64'(exp_nh_tbl[i]));
`endif
    tick(1'b0, '0, 1'b0, 1'b1, AW'(tbl[i].rd), 1'b0);
    chk("tbl_rd_data", 64'(rd_data), 64'(tbl[i].exp_rd));
  endtask

  initial begin
    logic [TOT-1:0] ones;
    logic [TOT-1:0] rm;
    bit seen;
    n_vec = 0;
    n_err = 0;
    ones = '1;
    model_clear();
    tbl[0] = '{word: 0,   val: 32'h0000_0001, rd: 0,   exp_rd: 32'h0000_0001};
    tbl[1] = '{word: 127, val: 32'h8000_0000, rd: 127, exp_rd: 32'h8000_0000};
    tbl[2] = '{word: 5,   val: 32'h0000_0001, rd: 5,   exp_rd: 32'h0000_0001};
    tbl[3] = '{word: 5,   val: 32'h0000_0001, rd: 5,   exp_rd: 32'h0000_0001};
    tbl[4] = '{word: 5,   val: 32'h0000_FFFF, rd: 5,   exp_rd: 32'h0000_FFFF};
    tbl[5] = '{word: 5,   val: 32'hFFFF_0000, rd: 5,   exp_rd: 32'hFFFF_FFFF};
`ifdef COV_NEW_DET_EN
    exp_nh_tbl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    RST_n = 1'b0; mask_in = '0; mask_vld = 0; clr = 0;
    rd_req = 0; rd_addr = '0; scan_start = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_ack", 64'(rd_ack), 64'(0));
    chk("rst_busy", 64'(scan_busy), 64'(0));
    chk("rst_done", 64'(scan_done), 64'(0));
    chk("rst_count", 64'(cov_count), 64'(0));
    RST_n = 1'b1;

    // Back-to-back reads of every word after reset.
    for (int k = 0; k < int'(WORDS); k++) tick(1'b0, '0, 1'b0, 1'b1, AW'(k), 1'b0);
    idle();
    chk("rst_count_after_reads", 64'(cov_count), 64'(0));

    // Corner bits of channels 0 and 7.
    for (int i = 0; i < 2; i++) apply_vec(i);
    run_scan(2);

    // Repeated and split masks into word 5.
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 2; i < 6; i++) apply_vec(i);
`ifdef COV_NEW_DET_EN
    chk("new_hit_cnt_3", 64'(new_hit_cnt), 64'(3));
`endif
    run_scan(32);

    // clr beats a same-cycle all-ones mask.
    tick(1'b1, ones, 1'b1, 1'b0, '0, 1'b0);
    chk("clr_count", 64'(cov_count), 64'(0));
    for (int k = 0; k < int'(WORDS); k++) begin
      tick(1'b0, '0, 1'b0, 1'b1, AW'(k), 1'b0);
      chk("clr_word_zero", 64'(rd_data), 64'(0));
    end

    // Asynchronous reset in the middle of a full-coverage scan.
    tick(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    run_scan(4096);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_rd_data", 64'(rd_data), 64'(0));
    chk("arst_rd_ack", 64'(rd_ack), 64'(0));
    chk("arst_busy", 64'(scan_busy), 64'(0));
    chk("arst_done", 64'(scan_done), 64'(0));
    chk("arst_count", 64'(cov_count), 64'(0));
`ifdef COV_NEW_DET_EN
    chk("arst_new_hit_cnt", 64'(new_hit_cnt), 64'(0));
`endif
    model_clear();
    @(negedge CLK);
    RST_n = 1'b1;
    run_scan(0);

    // clr on the 50th scan cycle aborts without a done pulse.
    tick(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    run_scan(4096);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i < 50; i++) tick(1'b0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("abort_busy", 64'(scan_busy), 64'(0));
    chk("abort_count", 64'(cov_count), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      idle();
      if (scan_done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'(0));
    run_scan(0);

    // Randomized sparse masks, reads and occasional clears.
    for (int i = 0; i < 400; i++) begin
      rm = '0;
      for (int j = 0; j < 2; j++) begin
        rm[$urandom_range(0, WORDS - 1)*RD_W +: RD_W] = $urandom & $urandom & $urandom;
      end
      tick(1'($urandom_range(0, 1)), rm, ($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS - 1)), 1'b0);
    end
    run_scan(model_pop());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
